// File: rtl/pattern_pkg.sv
// ============================================================================
// Module   : pattern_pkg
// Purpose  : Shared state encoding and defaults for the pattern entry checker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pattern_pkg;

    localparam int DIGIT_W_DEFAULT = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTER   = 3'd1,
        CHECK   = 3'd2,
        MATCH   = 3'd3,
        FAIL    = 3'd4,
        LOCKED  = 3'd5,
        PROGRAM = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/pattern_timer.sv
// ============================================================================
// Module   : pattern_timer
// Purpose  : Loadable down-counter; done is high while the count sits at zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pattern_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign done = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/pattern_entry_checker.sv
// ============================================================================
// Module   : pattern_entry_checker
// Purpose  : Collects a digit pattern, compares it with a stored key, tracks
//            failures with lockout and allows key reprogramming after a match.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pattern_entry_checker
    import pattern_pkg::*;
#(
    parameter int                              DIGIT_W      = DIGIT_W_DEFAULT,
    parameter int                              NUM_DIGITS   = 4,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0]   DEFAULT_KEY  = 16'h1234,
    parameter int                              MAX_ATTEMPTS = 3,
    parameter int                              HOLD_CYCLES  = 8,
    parameter int                              LOCK_CYCLES  = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                digit_pulse,
    input  logic                                key_pulse,
    input  logic [DIGIT_W-1:0]                  digit_in,
    output logic                                match,
    output logic                                fail,
    output logic                                locked,
    output logic                                prog_mode,
    output logic [$clog2(NUM_DIGITS+1)-1:0]     digit_count,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0]   attempts
);

    localparam int c_key_w = NUM_DIGITS * DIGIT_W;
    localparam int c_cnt_w = $clog2(NUM_DIGITS + 1);
    localparam int c_att_w = $clog2(MAX_ATTEMPTS + 1);
    localparam int c_tmax  = (HOLD_CYCLES > LOCK_CYCLES) ? HOLD_CYCLES : LOCK_CYCLES;
    localparam int c_tim_w = (c_tmax > 1) ? $clog2(c_tmax) : 1;

    localparam logic [c_tim_w-1:0] c_hold_val = c_tim_w'(HOLD_CYCLES - 1);
    localparam logic [c_tim_w-1:0] c_lock_val = c_tim_w'(LOCK_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(NUM_DIGITS - 1);
    localparam logic [c_att_w-1:0] c_att_max  = c_att_w'(MAX_ATTEMPTS);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_key_w-1:0]   r_entry;
    logic [c_key_w-1:0]   w_entry_nxt;
    logic [c_key_w-1:0]   r_shadow;
    logic [c_key_w-1:0]   w_shadow_nxt;
    logic [c_key_w-1:0]   r_key;
    logic [c_key_w-1:0]   w_key_nxt;
    logic [c_cnt_w-1:0]   r_digit_count;
    logic [c_cnt_w-1:0]   w_count_nxt;
    logic [c_att_w-1:0]   r_attempts;
    logic [c_att_w-1:0]   w_attempts_nxt;
    logic [c_att_w-1:0]   w_attempts_inc;
    logic                 w_timer_load;
    logic [c_tim_w-1:0]   w_timer_value;
    logic                 w_timer_done;
    logic                 r_match;
    logic                 r_fail;
    logic                 r_locked;
    logic                 r_prog_mode;

    assign w_attempts_inc = r_attempts + 1'b1;

    pattern_timer #(
        .WIDTH (c_tim_w)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (w_timer_load),
        .value (w_timer_value),
        .done  (w_timer_done)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_entry_nxt    = r_entry;
        w_shadow_nxt   = r_shadow;
        w_key_nxt      = r_key;
        w_count_nxt    = r_digit_count;
        w_attempts_nxt = r_attempts;
        w_timer_load   = 1'b0;
        w_timer_value  = c_hold_val;

        case (r_state)
            IDLE: begin
                if (digit_pulse) begin
                    w_entry_nxt = {r_entry[c_key_w-DIGIT_W-1:0], digit_in};
                    w_count_nxt = c_cnt_w'(1);
                    w_state_nxt = ENTER;
                end
            end

            ENTER: begin
                // An abort outranks a digit arriving in the same cycle.
                if (key_pulse) begin
                    w_count_nxt = '0;
                    w_state_nxt = IDLE;
                end else if (digit_pulse) begin
                    w_entry_nxt = {r_entry[c_key_w-DIGIT_W-1:0], digit_in};
                    w_count_nxt = r_digit_count + 1'b1;
                    if (r_digit_count == c_last_idx) begin
                        w_state_nxt = CHECK;
                    end
                end
            end

            CHECK: begin
                w_timer_load = 1'b1;
                if (r_entry == r_key) begin
                    w_attempts_nxt = '0;
                    w_state_nxt    = MATCH;
                end else begin
                    w_attempts_nxt = w_attempts_inc;
                    if (w_attempts_inc == c_att_max) begin
                        w_timer_value = c_lock_val;
                        w_count_nxt   = '0;
                        w_state_nxt   = LOCKED;
                    end else begin
                        w_state_nxt   = FAIL;
                    end
                end
            end

            MATCH: begin
                if (key_pulse) begin
                    w_count_nxt = '0;
                    w_state_nxt = PROGRAM;
                end else if (w_timer_done) begin
                    w_count_nxt = '0;
                    w_state_nxt = IDLE;
                end
            end

            FAIL: begin
                if (w_timer_done) begin
                    w_count_nxt = '0;
                    w_state_nxt = IDLE;
                end
            end

            LOCKED: begin
                if (w_timer_done) begin
                    w_attempts_nxt = '0;
                    w_state_nxt    = IDLE;
                end
            end

            PROGRAM: begin
                if (key_pulse) begin
                    w_count_nxt = '0;
                    w_state_nxt = IDLE;
                end else if (digit_pulse) begin
                    w_shadow_nxt = {r_shadow[c_key_w-DIGIT_W-1:0], digit_in};
                    w_count_nxt  = r_digit_count + 1'b1;
                    if (r_digit_count == c_last_idx) begin
                        w_key_nxt   = w_shadow_nxt;
                        w_count_nxt = '0;
                        w_state_nxt = IDLE;
                    end
                end
            end

            default: begin
                w_count_nxt = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_entry       <= '0;
            r_shadow      <= '0;
            r_key         <= DEFAULT_KEY;
            r_digit_count <= '0;
            r_attempts    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_entry       <= w_entry_nxt;
            r_shadow      <= w_shadow_nxt;
            r_key         <= w_key_nxt;
            r_digit_count <= w_count_nxt;
            r_attempts    <= w_attempts_nxt;
        end
    end

    // Result flags are registered copies of the state decode, so the result
    // appears on the second edge after the final digit is sampled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_match     <= 1'b0;
            r_fail      <= 1'b0;
            r_locked    <= 1'b0;
            r_prog_mode <= 1'b0;
        end else begin
            r_match     <= (r_state == MATCH);
            r_fail      <= (r_state == FAIL);
            r_locked    <= (r_state == LOCKED);
            r_prog_mode <= (r_state == PROGRAM);
        end
    end

    assign match       = r_match;
    assign fail        = r_fail;
    assign locked      = r_locked;
    assign prog_mode   = r_prog_mode;
    assign digit_count = r_digit_count;
    assign attempts    = r_attempts;

endmodule

`default_nettype wire

// File: tb/tb_pattern_entry_checker.sv
// ============================================================================
// Module   : tb_pattern_entry_checker
// Purpose  : Directed self-checking bench for pattern_entry_checker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pattern_entry_checker;

    logic       clk;
    logic       rst;
    logic       digit_pulse;
    logic       key_pulse;
    logic [3:0] digit_in;
    logic       match;
    logic       fail;
    logic       locked;
    logic       prog_mode;
    logic [2:0] digit_count;
    logic [1:0] attempts;

    int n_total;
    int n_bad;

    pattern_entry_checker dut (
        .clk         (clk),
        .rst         (rst),
        .digit_pulse (digit_pulse),
        .key_pulse   (key_pulse),
        .digit_in    (digit_in),
        .match       (match),
        .fail        (fail),
        .locked      (locked),
        .prog_mode   (prog_mode),
        .digit_count (digit_count),
        .attempts    (attempts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_total++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_digit(input logic [3:0] d, input int gap);
        @(negedge clk);
        digit_pulse = 1'b1;
        digit_in    = d;
        @(negedge clk);
        digit_pulse = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic press_key();
        @(negedge clk);
        key_pulse = 1'b1;
        @(negedge clk);
        key_pulse = 1'b0;
    endtask

    // Returns at the negedge just after the final digit has been sampled.
    task automatic enter4(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d);
        pulse_digit(a, 3);
        pulse_digit(b, 3);
        pulse_digit(c, 3);
        pulse_digit(d, 0);
    endtask

    // Samples one result flag for n cycles; first is the 1-based cycle it rose.
    task automatic measure(input int sel, input int n, output int first, output int len);
        logic v;
        first = -1;
        len   = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            v = (sel == 0) ? match : (sel == 1) ? fail : locked;
            if (v && first < 0) first = i;
            if (v) len++;
        end
    endtask

    function automatic int all_outs();
        return int'({match, fail, locked, prog_mode, digit_count, attempts});
    endfunction

    int first;
    int len;

    initial begin
        n_total     = 0;
        n_bad       = 0;
        rst         = 1'b1;
        digit_pulse = 1'b0;
        key_pulse   = 1'b0;
        digit_in    = 4'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("reset_outputs", all_outs(), 0);

        // Correct default key
        enter4(4'h1, 4'h2, 4'h3, 4'h4);
        measure(0, 12, first, len);
        check_eq("match_rise", first, 2);
        check_eq("match_len", len, 8);
        check_eq("match_attempts", int'(attempts), 0);

        // Wrong then right
        enter4(4'h1, 4'h2, 4'h3, 4'h5);
        measure(1, 12, first, len);
        check_eq("fail_rise", first, 2);
        check_eq("fail_len", len, 8);
        check_eq("fail_attempts", int'(attempts), 1);
        enter4(4'h1, 4'h2, 4'h3, 4'h4);
        measure(0, 12, first, len);
        check_eq("rematch_len", len, 8);
        check_eq("rematch_attempts", int'(attempts), 0);

        // Three wrong entries lead to lockout
        enter4(4'h0, 4'h0, 4'h0, 4'h0);
        measure(1, 12, first, len);
        check_eq("wrong1_attempts", int'(attempts), 1);
        enter4(4'h9, 4'h9, 4'h9, 4'h9);
        measure(1, 12, first, len);
        check_eq("wrong2_fail_len", len, 8);
        check_eq("wrong2_attempts", int'(attempts), 2);
        enter4(4'h4, 4'h3, 4'h2, 4'h1);
        fork
            measure(2, 30, first, len);
            begin
                repeat (4) @(negedge clk);
                digit_pulse = 1'b1;
                digit_in    = 4'h1;
                @(negedge clk);
                digit_pulse = 1'b0;
                @(negedge clk);
                check_eq("lock_digit_count", int'(digit_count), 0);
                check_eq("lock_attempts", int'(attempts), 3);
                check_eq("lock_no_fail", int'(fail), 0);
            end
        join
        check_eq("lock_rise", first, 2);
        check_eq("lock_len", len, 16);
        check_eq("post_lock_attempts", int'(attempts), 0);
        pulse_digit(4'h1, 0);
        check_eq("post_lock_idle_digit", int'(digit_count), 1);
        press_key();
        check_eq("post_lock_abort", int'(digit_count), 0);

        // Abort coincident with the third digit
        pulse_digit(4'h1, 3);
        pulse_digit(4'h2, 3);
        @(negedge clk);
        digit_pulse = 1'b1;
        key_pulse   = 1'b1;
        digit_in    = 4'h3;
        @(negedge clk);
        digit_pulse = 1'b0;
        key_pulse   = 1'b0;
        check_eq("abort_digit_count", int'(digit_count), 0);
        check_eq("abort_attempts", int'(attempts), 0);
        enter4(4'h1, 4'h2, 4'h3, 4'h4);
        measure(0, 12, first, len);
        check_eq("abort_then_match", len, 8);

        // Reprogram the key to 9876
        enter4(4'h1, 4'h2, 4'h3, 4'h4);
        repeat (2) @(negedge clk);
        check_eq("prog_pre_match", int'(match), 1);
        press_key();
        @(negedge clk);
        check_eq("prog_mode_on", int'(prog_mode), 1);
        check_eq("prog_count0", int'(digit_count), 0);
        pulse_digit(4'h9, 3);
        pulse_digit(4'h8, 3);
        pulse_digit(4'h7, 0);
        check_eq("prog_count3", int'(digit_count), 3);
        check_eq("prog_mode_mid", int'(prog_mode), 1);
        pulse_digit(4'h6, 0);
        @(negedge clk);
        check_eq("prog_mode_off", int'(prog_mode), 0);
        check_eq("prog_done_count", int'(digit_count), 0);
        repeat (3) @(negedge clk);
        enter4(4'h1, 4'h2, 4'h3, 4'h4);
        measure(1, 12, first, len);
        check_eq("old_key_fails", len, 8);
        enter4(4'h9, 4'h8, 4'h7, 4'h6);
        measure(0, 12, first, len);
        check_eq("new_key_matches", len, 8);

        // Reset mid-entry restores the default key
        pulse_digit(4'h1, 3);
        pulse_digit(4'h2, 3);
        pulse_digit(4'h3, 0);
        check_eq("mid_entry_count", int'(digit_count), 3);
        reset_dut();
        check_eq("mid_entry_reset", all_outs(), 0);
        enter4(4'h1, 4'h2, 4'h3, 4'h4);
        measure(0, 12, first, len);
        check_eq("default_key_back", len, 8);

        // Reset mid-program discards the partial key
        enter4(4'h1, 4'h2, 4'h3, 4'h4);
        repeat (2) @(negedge clk);
        press_key();
        pulse_digit(4'h5, 3);
        pulse_digit(4'h5, 0);
        check_eq("mid_prog_mode", int'(prog_mode), 1);
        reset_dut();
        check_eq("mid_prog_reset", all_outs(), 0);
        enter4(4'h1, 4'h2, 4'h3, 4'h4);
        measure(0, 12, first, len);
        check_eq("key_after_prog_reset", len, 8);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
